textcon_term_ctrl: RTL and testbench



---
 rtl/textcon_term_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_textcon_term_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/textcon_term_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : textcon_term_ctrl
// Description : Terminal-style write sequencer for the text-console character
//               buffer. Interprets a byte stream (printables and a small set
//               of control codes), tracks the cursor, and scrolls by moving a
//               hardware row offset instead of copying buffer contents.
// Revision    : 1.0 - initial release
// ============================================================================
module textcon_term_ctrl #(
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int ADDR_W  = 12,
    parameter int BLINK_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [4:0]        scroll_row,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              cursor_on,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_CLRROW = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_CELL    = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] c_LAST_COL_A   = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] c_COLS_A       = ADDR_W'(COLS);
    localparam logic [6:0]        c_LAST_COL     = 7'(COLS - 1);
    localparam logic [4:0]        c_LAST_ROW     = 5'(ROWS - 1);
    localparam logic [5:0]        c_ROWS6        = 6'(ROWS);
    localparam logic [7:0]        c_SPACE        = 8'h20;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   r_clr_base;
    logic [6:0]          r_col;
    logic [4:0]          r_row;
    logic [4:0]          r_scroll;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [7:0]          r_wr_data;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic                r_cursor_on;

    logic [5:0]          w_row_sum;
    logic [5:0]          w_phys_row;
    logic [ADDR_W-1:0]   w_cell_addr;
    logic [4:0]          w_scroll_next;
    logic                w_accept;
    logic                w_printable;
    logic                w_newline;

    // Logical row to physical buffer row: at most one wrap, so one subtract.
    assign w_row_sum     = {1'b0, r_row} + {1'b0, r_scroll};
    assign w_phys_row    = (w_row_sum >= c_ROWS6) ? (w_row_sum - c_ROWS6) : w_row_sum;
    assign w_cell_addr   = ADDR_W'(w_phys_row) * c_COLS_A + ADDR_W'(r_col);
    assign w_scroll_next = (r_scroll == c_LAST_ROW) ? 5'd0 : (r_scroll + 5'd1);

    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    // Line feed, or a printable landing in the last column, advances the line.
    assign w_newline   = w_accept &&
                         ((w_printable && (r_col == c_LAST_COL)) || (in_data == 8'h0A));

    // Free-running blink divider; the cursor phase flips on every wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_cursor_on <= 1'b0;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
            if (&r_blink_cnt) begin
                r_cursor_on <= ~r_cursor_on;
            end
        end
    end

    // Control FSM: screen clear, byte interpretation and exposed-row clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_CLEAR;
            r_clr_cnt  <= '0;
            r_clr_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_scroll   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_clr_cnt;
                    r_wr_data <= c_SPACE;
                    if (r_clr_cnt == c_LAST_CELL) begin
                        r_clr_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end

                ST_CLRROW: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_clr_base + r_clr_cnt;
                    r_wr_data <= c_SPACE;
                    if (r_clr_cnt == c_LAST_COL_A) begin
                        r_clr_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_cell_addr;
                            r_wr_data <= in_data;
                            r_col     <= (r_col == c_LAST_COL) ? 7'd0 : (r_col + 7'd1);
                        end else begin
                            case (in_data)
                                8'h0D: r_col <= '0;
                                8'h08: if (r_col != 7'd0) r_col <= r_col - 7'd1;
                                8'h0C: begin
                                    r_col     <= '0;
                                    r_row     <= '0;
                                    r_scroll  <= '0;
                                    r_clr_cnt <= '0;
                                    r_state   <= ST_CLEAR;
                                end
                                default: ;
                            endcase
                        end
                    end
                    // The row to blank is the one that was at the top before
                    // the scroll offset advanced.
                    if (w_newline) begin
                        if (r_row != c_LAST_ROW) begin
                            r_row <= r_row + 5'd1;
                        end else begin
                            r_scroll   <= w_scroll_next;
                            r_clr_base <= ADDR_W'(r_scroll) * c_COLS_A;
                            r_clr_cnt  <= '0;
                            r_state    <= ST_CLRROW;
                        end
                    end
                end

                default: begin
                    r_clr_cnt <= '0;
                    r_state   <= ST_CLEAR;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign scroll_row = r_scroll;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign cursor_on  = r_cursor_on;

endmodule
`default_nettype wire

// File: tb/tb_textcon_term_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_textcon_term_ctrl
// Description : Scoreboard bench for textcon_term_ctrl. A terminal model
//               predicts buffer writes and cursor/scroll state; a monitor
//               pops predicted writes whenever the controller strobes wr_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_textcon_term_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int AW    = 12;
    localparam int BW    = 6;
    localparam int CELLS = COLS * ROWS;
    localparam int LIMIT = 5000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [4:0]    scroll_row;
    logic [6:0]    cursor_col;
    logic [4:0]    cursor_row;
    logic          cursor_on;
    logic          busy;

    textcon_term_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .BLINK_W(BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .scroll_row(scroll_row), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .cursor_on(cursor_on), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  m_col, m_row, m_scroll, m_block;
    int  bcnt  = 0;
    bit  chk_on = 1'b0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- terminal reference model ----------------
    function automatic void push_clear(int base, int n);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = base + i;
            w.data = 32'h20;
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_newline();
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            push_clear(m_scroll * COLS, COLS);
            m_scroll = (m_scroll + 1) % ROWS;
            m_block  = COLS;
        end
    endfunction

    function automatic void model_byte(int b);
        wr_t w;
        m_block = 0;
        if (b >= 32'h20 && b <= 32'h7E) begin
            w.addr = ((m_row + m_scroll) % ROWS) * COLS + m_col;
            w.data = b;
            exp_q.push_back(w);
            if (m_col == COLS - 1) begin
                m_col = 0;
                model_newline();
            end else begin
                m_col++;
            end
        end else if (b == 32'h0D) begin
            m_col = 0;
        end else if (b == 32'h0A) begin
            model_newline();
        end else if (b == 32'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 32'h0C) begin
            m_col    = 0;
            m_row    = 0;
            m_scroll = 0;
            push_clear(0, CELLS);
            m_block  = CELLS;
        end
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        bcnt = rst_n ? bcnt + 1 : 0;
    end

    always @(negedge clk) begin : mon
        wr_t e;
        if (chk_on) begin
            chk("cursor_on", int'(cursor_on), (bcnt / (1 << BW)) % 2);
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                             wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(wr_addr), e.addr);
                    chk("wr_data", int'(wr_data), e.data);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_state();
        chk("cursor_col", int'(cursor_col), m_col);
        chk("cursor_row", int'(cursor_row), m_row);
        chk("scroll_row", int'(scroll_row), m_scroll);
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        exp_q.delete();
        m_col = 0; m_row = 0; m_scroll = 0; m_block = 0;
        chk_on = 1'b1;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_cursor_on", int'(cursor_on), 0);
        check_state();
        push_clear(0, CELLS);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: in_ready still %0d after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        chk("pending_writes", exp_q.size(), 0);
        chk("idle_busy", int'(busy), 0);
        check_state();
    endtask

    task automatic send(int b, bit measure);
        int n = 0;
        @(negedge clk);
        check_state();
        in_data  = 8'(b);
        in_valid = 1'b1;
        while (!in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready %0d after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
            return;
        end
        model_byte(b);
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (measure && m_block > 0) begin
            n = 0;
            @(negedge clk);
            while (!in_ready && n < LIMIT) begin
                n++;
                @(negedge clk);
            end
            chk("blocked_cycles", n, m_block);
            chk("busy_after_block", int'(busy), 0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int r, b;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        do_reset(3);
        wait_idle();

        send(32'h41, 1'b1);
        send(32'h42, 1'b1);
        @(negedge clk);
        chk("col_after_AB", int'(cursor_col), 2);

        send(32'h0D, 1'b1);
        for (int i = 0; i < COLS; i++) send(32'h21 + (i % 90), 1'b1);
        @(negedge clk);
        chk("row_after_80", int'(cursor_row), 1);
        send(32'h5A, 1'b1);

        while (m_row < ROWS - 1) send(32'h0A, 1'b1);
        send(32'h0A, 1'b1);
        @(negedge clk);
        chk("scroll_after_lf", int'(scroll_row), 1);
        send(32'h0D, 1'b1);
        send(32'h58, 1'b1);

        send(32'h0D, 1'b1);
        send(32'h08, 1'b1);
        send(32'h51, 1'b1);
        send(32'h08, 1'b1);
        send(32'h52, 1'b1);
        send(32'h0D, 1'b1);
        send(32'h07, 1'b1);

        // abort an exposed-row clear with a one-cycle reset
        send(32'h0A, 1'b0);
        repeat (20) @(negedge clk);
        do_reset(1);
        wait_idle();
        chk("scroll_after_abort", int'(scroll_row), 0);

        while (m_row < ROWS - 1) send(32'h0A, 1'b1);
        repeat (5) send(32'h0A, 1'b1);
        @(negedge clk);
        chk("scroll_before_ff", int'(scroll_row), 5);
        send(32'h0C, 1'b1);
        wait_idle();

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 60)      b = 32'h20 + $urandom_range(0, 94);
            else if (r < 72) b = 32'h0A;
            else if (r < 80) b = 32'h0D;
            else if (r < 87) b = 32'h08;
            else if (r < 98) b = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(127, 255);
            else             b = 32'h0C;
            send(b, 1'($urandom_range(0, 1)));
        end

        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
